i2c_write_arbiter: RTL



---
 rtl/i2c_arb_pkg.sv | 16 +
 rtl/i2c_write_arbiter_rr_pick.sv | 35 +++
 rtl/i2c_write_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the I2C write arbiter.
// State encoding, transfer word width and retry counter width.
package i2c_arb_pkg;

    localparam int I2C_WORD_W = 24;
    localparam int RETRY_W    = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_XFER,
        S_CHECK,
        S_GAP
    } state_t;

endpackage

// File: rtl/i2c_write_arbiter_rr_pick.sv
// Combinational round-robin selector: search starts one past the
// last grant and wraps from N_REQ-1 back to 0.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDXW  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDXW-1:0]  last_i,
    output logic [IDXW-1:0]  win_o,
    output logic             valid_o
);

    logic [IDXW:0]   sum;
    logic [IDXW-1:0] cand;

    // First requester found after the last grant wins
    always_comb begin
        win_o   = '0;
        valid_o = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            sum = {1'b0, last_i} + (IDXW+1)'(k);
            if (sum >= (IDXW+1)'(N_REQ)) begin
                sum = sum - (IDXW+1)'(N_REQ);
            end
            cand = sum[IDXW-1:0];
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                win_o   = cand;
            end
        end
    end

endmodule

// File: rtl/i2c_write_arbiter.sv
// Round-robin arbiter sharing one I2C write controller among N_REQ
// requesters, with NACK retry. Optional watchdog: I2C_ARB_TIMEOUT_EN.
module i2c_write_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int MAX_RETRY   = 3,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                          iCLK,
    input  logic                          iRST,
    input  logic [N_REQ-1:0]              iREQ,
    input  logic [I2C_WORD_W*N_REQ-1:0]   iREQ_DATA,
    output logic [N_REQ-1:0]              oDONE,
    output logic [N_REQ-1:0]              oERR,
    output logic                          oBUSY,
    output logic [$clog2(N_REQ)-1:0]      oGRANT_IDX,
    output logic [I2C_WORD_W-1:0]         oI2C_DATA,
    output logic                          oI2C_GO,
    input  logic                          iI2C_END,
    input  logic                          iI2C_ACK
);

    localparam int IDXW    = $clog2(N_REQ);
    localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t                 state_q, state_d;
    logic [IDXW-1:0]        idx_q;
    logic [IDXW-1:0]        ptr_q;
    logic [I2C_WORD_W-1:0]  data_q;
    logic [RETRY_W-1:0]     retry_q;
    logic                   rtr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   to_q;
    logic                   tout_hit;
    logic                   gap_done;
    logic                   nack_retry;
    logic [IDXW-1:0]        win;
    logic                   pick_v;
    logic [I2C_WORD_W-1:0]  pick_data;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDXW  (IDXW)
    ) u_pick (
        .req_i   (iREQ),
        .last_i  (ptr_q),
        .win_o   (win),
        .valid_o (pick_v)
    );

    // Transfer word of the current round-robin winner
    always_comb begin
        pick_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IDXW'(i)) begin
                pick_data = iREQ_DATA[I2C_WORD_W*i +: I2C_WORD_W];
            end
        end
    end

    assign gap_done   = (state_q == S_GAP) &&
                        (cnt_q == CNT_W'(GAP_CYC - 1));
    assign nack_retry = iI2C_ACK && !to_q &&
                        (int'(retry_q) < MAX_RETRY);

`ifdef I2C_ARB_TIMEOUT_EN
    assign tout_hit = ((state_q == S_START) || (state_q == S_XFER)) &&
                      (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Remember that this attempt ended by watchdog, not by END
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            to_q <= 1'b0;
        end else if (tout_hit) begin
            to_q <= 1'b1;
        end else if (state_q == S_GAP) begin
            to_q <= 1'b0;
        end
    end
`else
    assign tout_hit = 1'b0;
    assign to_q     = 1'b0;
`endif

    // State register
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_v) state_d = S_START;
            end
            S_START: begin
                if (tout_hit)       state_d = S_CHECK;
                else if (!iI2C_END) state_d = S_XFER;
            end
            S_XFER: begin
                if (tout_hit || iI2C_END) state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_done) state_d = rtr_q ? S_START : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; result pulses live in CHECK
    always_comb begin
        oDONE   = '0;
        oERR    = '0;
        oI2C_GO = (state_q == S_START) || (state_q == S_XFER);
        oBUSY   = (state_q != S_IDLE);
        if (state_q == S_CHECK) begin
            if (to_q)             oERR[idx_q]  = 1'b1;
            else if (!iI2C_ACK)   oDONE[idx_q] = 1'b1;
            else if (!nack_retry) oERR[idx_q]  = 1'b1;
        end
    end

    assign oGRANT_IDX = idx_q;
    assign oI2C_DATA  = data_q;

    // Grant latch and retry bookkeeping
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            idx_q   <= '0;
            ptr_q   <= IDXW'(N_REQ - 1);
            data_q  <= '0;
            retry_q <= '0;
            rtr_q   <= 1'b0;
        end else begin
            if ((state_q == S_IDLE) && pick_v) begin
                idx_q   <= win;
                ptr_q   <= win;
                data_q  <= pick_data;
                retry_q <= '0;
                rtr_q   <= 1'b0;
            end
            if (state_q == S_CHECK) begin
                rtr_q <= nack_retry;
                if (nack_retry) retry_q <= retry_q + RETRY_W'(1);
            end
        end
    end

    // Shared cycle counter: GAP length and, optionally, the watchdog
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cnt_q <= '0;
        end else begin
            unique case (state_q)
                S_GAP: cnt_q <= gap_done ? '0 : cnt_q + CNT_W'(1);
`ifdef I2C_ARB_TIMEOUT_EN
                S_START, S_XFER: cnt_q <= cnt_q + CNT_W'(1);
`endif
                default: cnt_q <= '0;
            endcase
        end
    end

endmodule
